seq_step_scheduler: RTL and testbench

SEQ_STEP_SCHEDULER -- requirements
Module: seq_step_scheduler

---
 rtl/seq_step_scheduler.sv | 145 ++++++++++++++
 tb/tb_seq_step_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_step_scheduler.sv
// Eight-step tone sequencer: CPU-programmed period, per-step frequency words and step mask.
// Advances one step every eff_period clocks while running and gates the tone per step.
//
// state | meaning
// IDLE  | stopped; step and count forced to 0, outputs dark
// RUN   | count advances each clk, step advances on period wrap
// PAUSE | step and count frozen, led shows held step, tone off
module seq_step_scheduler #(
    parameter int DATA_W     = 32,
    parameter int DIV_W      = 24,
    parameter int DEF_PERIOD = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [7:0]        kbd_in,
    output logic [15:0]       freq_out,
    output logic              snd_en,
    output logic [7:0]        led_out,
    output logic              step_tick
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   period;
    logic [DIV_W-1:0]   count, count_nxt;
    logic [DIV_W-1:0]   eff_period;
    logic [7:0]         mask;
    logic [7:0]         eff_mask;
    logic [15:0]        freq [8];
    logic               use_kbd;
    logic [2:0]         step, step_nxt;
    logic               tick, tick_nxt;
    logic               wr_en;
    logic               ctrl_wr;
    logic [DATA_W-1:0]  rd_data;
    logic               unused_bits;

    assign wr_en       = sel & we;
    assign ctrl_wr     = wr_en && (addr == 4'd0);
    assign eff_period  = (period < DIV_W'(2)) ? DIV_W'(2) : period;
    assign unused_bits = ^data_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            period  <= DIV_W'(DEF_PERIOD);
            mask    <= 8'hFF;
            use_kbd <= 1'b0;
            for (int i = 0; i < 8; i++) freq[i] <= '0;
        end else if (wr_en) begin
            case (addr)
                4'd0: use_kbd <= data_in[2];
                4'd1: period  <= data_in[DIV_W-1:0];
                4'd2: mask    <= data_in[7:0];
                default: if (addr[3]) freq[addr[2:0]] <= data_in[15:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            step  <= '0;
            count <= '0;
            tick  <= 1'b0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            count <= count_nxt;
            tick  <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        count_nxt = count;
        tick_nxt  = 1'b0;
        case (state)
            RUN: begin
                // >= so a PERIOD shrink below the current count wraps at once
                if (count >= eff_period - DIV_W'(1)) begin
                    count_nxt = '0;
                    step_nxt  = step + 3'd1;
                    tick_nxt  = 1'b1;
                end else begin
                    count_nxt = count + DIV_W'(1);
                end
            end
            PAUSE: ;
            default: begin
                step_nxt  = '0;
                count_nxt = '0;
            end
        endcase
        if (ctrl_wr) begin
            if (!data_in[0])     state_nxt = IDLE;
            else if (data_in[1]) state_nxt = PAUSE;
            else                 state_nxt = RUN;
            if (state_nxt == IDLE) begin
                step_nxt  = '0;
                count_nxt = '0;
                tick_nxt  = 1'b0;
            end else if (state_nxt == PAUSE) begin
                step_nxt  = (state == IDLE) ? 3'd0 : step;
                count_nxt = (state == IDLE) ? '0 : count;
                tick_nxt  = 1'b0;
            end else if (state == IDLE) begin
                step_nxt  = '0;
                count_nxt = '0;
                tick_nxt  = 1'b1;
            end
            // restart overrides any coincident step advance
            if (data_in[0] && data_in[3]) begin
                step_nxt  = '0;
                count_nxt = '0;
                tick_nxt  = (state_nxt == RUN);
            end
        end
    end

    assign eff_mask  = use_kbd ? kbd_in : mask;
    assign snd_en    = (state == RUN) && eff_mask[step] && (count < (eff_period >> 1));
    assign freq_out  = snd_en ? freq[step] : 16'd0;
    assign led_out   = (state == IDLE) ? 8'd0 : (8'd1 << step);
    assign step_tick = tick;

    always_comb begin
        rd_data = '0;
        case (addr)
            4'd0: rd_data[6:0] = {step, 1'b0, use_kbd, (state == PAUSE), (state == RUN)};
            4'd1: rd_data[DIV_W-1:0] = period;
            4'd2: rd_data[7:0] = mask;
            default: if (addr[3]) rd_data[15:0] = freq[addr[2:0]];
        endcase
    end

    assign data_out = sel ? rd_data : '0;

endmodule

// File: tb/tb_seq_step_scheduler.sv
// Bench for seq_step_scheduler: directed scenarios then random bus traffic,
// every cycle compared against a step/phase reference model.
module tb_seq_step_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic [7:0]  kbd_in = 8'd0;
    logic [15:0] freq_out;
    logic        snd_en;
    logic [7:0]  led_out;
    logic        step_tick;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    bit          m_running, m_paused, m_use_kbd, m_tick;
    int          m_step, m_count;
    int unsigned m_period = 1000000;
    logic [7:0]  m_mask = 8'hFF;
    logic [15:0] m_freq [8];

    seq_step_scheduler #(.DATA_W(32), .DIV_W(24), .DEF_PERIOD(1000000)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .kbd_in(kbd_in),
        .freq_out(freq_out), .snd_en(snd_en), .led_out(led_out),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_of(input int unsigned p);
        return (p < 2) ? 2 : int'(p);
    endfunction

    task automatic check_outputs();
        int         eff;
        logic [7:0] em;
        logic [7:0] exp_led;
        bit         exp_snd;
        eff     = eff_of(m_period);
        em      = m_use_kbd ? kbd_in : m_mask;
        exp_snd = m_running && em[m_step] && (m_count < eff / 2);
        exp_led = (m_running || m_paused) ? (8'd1 << m_step) : 8'd0;
        chk("led_out", led_out, exp_led);
        chk("step_tick", step_tick, m_tick);
        chk("snd_en", snd_en, exp_snd);
        chk("freq_out", freq_out, exp_snd ? m_freq[m_step] : 16'd0);
    endtask

    // one clock: decide the model's next state from pre-edge inputs, then compare
    task automatic tick();
        int          eff;
        int          n_step, n_count;
        bit          n_tick, n_run, n_pause, n_use;
        int unsigned n_period;
        logic [7:0]  n_mask;
        logic [15:0] n_freq [8];
        eff = eff_of(m_period);
        n_step = m_step; n_count = m_count; n_tick = 0;
        n_run = m_running; n_pause = m_paused; n_use = m_use_kbd;
        n_period = m_period; n_mask = m_mask;
        for (int i = 0; i < 8; i++) n_freq[i] = m_freq[i];
        if (rst === 1'b0) begin
            n_run = 0; n_pause = 0; n_step = 0; n_count = 0; n_use = 0;
            n_period = 1000000; n_mask = 8'hFF;
            for (int i = 0; i < 8; i++) n_freq[i] = 16'd0;
        end else begin
            if (m_running) begin
                if (m_count + 1 >= eff) begin
                    n_count = 0; n_step = (m_step + 1) % 8; n_tick = 1;
                end else begin
                    n_count = m_count + 1;
                end
            end
            if (sel && we) begin
                if (addr == 4'd0) begin
                    n_use = data_in[2];
                    if (!data_in[0]) begin
                        n_run = 0; n_pause = 0; n_step = 0; n_count = 0; n_tick = 0;
                    end else if (data_in[1]) begin
                        n_step = m_step; n_count = m_count; n_tick = 0;
                        n_run = 0; n_pause = 1;
                    end else begin
                        if (!m_running && !m_paused) n_tick = 1;
                        n_run = 1; n_pause = 0;
                    end
                    if (data_in[0] && data_in[3]) begin
                        n_step = 0; n_count = 0; n_tick = n_run;
                    end
                end else if (addr == 4'd1) n_period = data_in[23:0];
                else if (addr == 4'd2) n_mask = data_in[7:0];
                else if (addr >= 4'd8) n_freq[addr - 4'd8] = data_in[15:0];
            end
        end
        @(posedge clk);
        m_step = n_step; m_count = n_count; m_tick = n_tick;
        m_running = n_run; m_paused = n_pause; m_use_kbd = n_use;
        m_period = n_period; m_mask = n_mask;
        for (int i = 0; i < 8; i++) m_freq[i] = n_freq[i];
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] a);
        logic [31:0] exp;
        exp = 32'd0;
        case (a)
            4'd0: exp = {25'd0, 3'(m_step), 1'b0, m_use_kbd, m_paused, m_running};
            4'd1: exp = m_period;
            4'd2: exp = {24'd0, m_mask};
            default: if (a >= 4'd8) exp = {16'd0, m_freq[a - 4'd8]};
        endcase
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        chk("data_out", data_out, exp);
        sel = 1'b0;
        #1;
    endtask

    initial begin
        int n_ticks, n_snd, g;
        for (int i = 0; i < 8; i++) m_freq[i] = 16'd0;

        // reset and default register values
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        run(1);
        sel = 1'b1; addr = 4'd0; #1; chk("rst_ctrl", data_out, 32'd0);
        addr = 4'd1; #1; chk("rst_period", data_out, 32'd1000000);
        addr = 4'd2; #1; chk("rst_mask", data_out, 32'h0000_00FF);
        sel = 1'b0; #1; chk("sel0_read", data_out, 32'd0);
        chk("rst_led", led_out, 8'd0);

        // period 4, frequency table, start
        wr(4'd1, 32'd4);
        for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'(100 + i));
        rd_chk(4'd9);
        wr(4'd0, 32'd1);
        chk("entry_tick", step_tick, 1'b1);
        chk("entry_led", led_out, 8'h01);
        n_ticks = 0; n_snd = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            n_ticks += int'(step_tick);
            n_snd   += int'(snd_en);
        end
        chk("tick_count_32", n_ticks, 8);
        chk("snd_count_32", n_snd, 16);
        rd_chk(4'd0);

        // degenerate periods
        wr(4'd1, 32'd0);
        run(8);
        wr(4'd1, 32'd1);
        run(8);

        // stored mask, then keyboard mask
        wr(4'd1, 32'd4);
        wr(4'd2, 32'h05);
        run(20);
        kbd_in = 8'h80;
        wr(4'd0, 32'd5);
        run(36);
        rd_chk(4'd0);

        // pause at step 3, count 1 then resume
        wr(4'd0, 32'd1);
        g = 0;
        while (!(m_step == 3 && m_count == 1) && g < 100) begin tick(); g++; end
        chk("reach_s3c1", g < 100, 1'b1);
        wr(4'd0, 32'd3);
        run(5);
        chk("pause_led", led_out, 8'h08);
        rd_chk(4'd0);
        wr(4'd0, 32'd1);
        run(2);
        chk("resume_no_tick", step_tick, 1'b0);
        run(1);
        chk("resume_tick", step_tick, 1'b1);
        chk("resume_led", led_out, 8'h10);

        // restart exactly on the wrap cycle
        g = 0;
        while (m_count != 3 && g < 100) begin tick(); g++; end
        chk("reach_wrap", g < 100, 1'b1);
        wr(4'd0, 32'h9);
        chk("restart_led", led_out, 8'h01);
        chk("restart_tick", step_tick, 1'b1);
        run(1);
        chk("restart_single", step_tick, 1'b0);

        // reset mid-run
        run(3);
        rst = 1'b0;
        run(1);
        chk("rst_abort_led", led_out, 8'd0);
        rst = 1'b1;
        run(2);

        // random traffic
        for (int it = 0; it < 700; it++) begin
            int r;
            logic [3:0] a;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            kbd_in = 8'($urandom);
            if (r < 5) begin
                tick();
            end else if (r < 8) begin
                a = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) a = 4'd0;
                d = $urandom;
                if (a == 4'd1) d = $urandom_range(0, 6);
                if (a == 4'd0) begin
                    d = 32'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                end
                wr(a, d);
            end else if (r == 8) begin
                rd_chk(4'($urandom_range(0, 15)));
                tick();
            end else begin
                if ($urandom_range(0, 9) == 0) rst = 1'b0;
                tick();
                rst = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
